// File: rtl/uart_reg_assembler_if.sv
// Byte-stream input and assembled-register output bundle for uart_reg_assembler.
// The slave side is the assembler; the master side feeds bytes and watches results.
interface uart_reg_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] uart_reg;
  logic        uart_ready;
  logic        frame_err;
  logic [7:0]  err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  uart_reg, uart_ready, frame_err, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output uart_reg, uart_ready, frame_err, err_cnt
  );
endinterface

// File: rtl/uart_reg_assembler.sv
// Assembles HEADER + 4 payload bytes + XOR checksum frames into a 32-bit register,
// flagging checksum failures and inter-byte timeouts with a saturating error count.
module uart_reg_assembler #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input logic                 clk,
  input logic                 rst,
  uart_reg_assembler_if.slave bus
);

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_CHECK} state_t;

  state_t      state;
  logic [31:0] shift_reg;
  logic [7:0]  xor_acc;
  logic [1:0]  byte_cnt;
  logic [31:0] timer;
  logic [31:0] uart_reg_q;
  logic        uart_ready_q;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;
  logic        timer_expired;

  // timer counts idle cycles after the first one, so the error pulse lands
  // exactly TIMEOUT cycles after the last accepted strobe
  assign timer_expired = !bus.rx_valid && (timer == TIMEOUT - 32'd2);

  assign bus.uart_reg   = uart_reg_q;
  assign bus.uart_ready = uart_ready_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_cnt    = err_cnt_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_HUNT;
      shift_reg    <= 32'h0;
      xor_acc      <= 8'h0;
      byte_cnt     <= 2'd0;
      timer        <= 32'h0;
      uart_reg_q   <= 32'h0;
      uart_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 8'h0;
    end else begin
      uart_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state)
        S_HUNT: begin
          timer <= 32'h0;
          if (bus.rx_valid && bus.rx_data == HEADER) begin
            state    <= S_DATA;
            byte_cnt <= 2'd0;
            xor_acc  <= 8'h0;
          end
        end
        S_DATA: begin
          if (bus.rx_valid) begin
            shift_reg <= {shift_reg[23:0], bus.rx_data};
            xor_acc   <= xor_acc ^ bus.rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
            timer     <= 32'h0;
            if (byte_cnt == 2'd3) state <= S_CHECK;
          end else if (timer_expired) begin
            frame_err_q <= 1'b1;
            err_cnt_q   <= sat_inc(err_cnt_q);
            timer       <= 32'h0;
            state       <= S_HUNT;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_CHECK: begin
          if (bus.rx_valid) begin
            timer <= 32'h0;
            state <= S_HUNT;
            if (bus.rx_data == xor_acc) begin
              uart_reg_q   <= shift_reg;
              uart_ready_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= sat_inc(err_cnt_q);
            end
          end else if (timer_expired) begin
            frame_err_q <= 1'b1;
            err_cnt_q   <= sat_inc(err_cnt_q);
            timer       <= 32'h0;
            state       <= S_HUNT;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_assembler.sv
// Drives directed and random byte streams into uart_reg_assembler and compares
// every cycle against a frame-level reference model.
module tb_uart_reg_assembler;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_reg_assembler_if bus ();

  uart_reg_assembler #(
    .HEADER  (HDR),
    .TIMEOUT (32'(TMO))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ready_seen = 0;

  // reference model: frame-level view (in a frame or not, bytes so far, idle time)
  bit         m_in_frame;
  logic [7:0] m_q[$];
  int         m_idle;
  logic [31:0] m_reg;
  bit         m_ready;
  bit         m_err;
  int         m_err_cnt;

  function automatic void model_reset();
    m_in_frame = 0;
    m_q.delete();
    m_idle    = 0;
    m_reg     = 32'h0;
    m_ready   = 0;
    m_err     = 0;
    m_err_cnt = 0;
  endfunction

  function automatic void model_error();
    m_err = 1;
    if (m_err_cnt < 255) m_err_cnt++;
  endfunction

  function automatic void model_step(bit v, logic [7:0] d);
    m_ready = 0;
    m_err   = 0;
    if (!m_in_frame) begin
      if (v && d == HDR) begin
        m_in_frame = 1;
        m_q.delete();
        m_idle = 0;
      end
    end else if (v) begin
      m_idle = 0;
      if (m_q.size() < 4) begin
        m_q.push_back(d);
      end else begin
        if (d == (m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3])) begin
          m_reg   = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_ready = 1;
        end else begin
          model_error();
        end
        m_in_frame = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO - 1) begin
        model_error();
        m_in_frame = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("uart_ready", 32'(bus.uart_ready), 32'(m_ready));
    check("frame_err",  32'(bus.frame_err),  32'(m_err));
    check("err_cnt",    32'(bus.err_cnt),    32'(m_err_cnt));
    check("uart_reg",   bus.uart_reg,        m_reg);
    check("ready_err_exclusive", 32'(bus.uart_ready & bus.frame_err), 32'd0);
    if (bus.uart_ready === 1'b1) ready_seen++;
  endtask

  // one cycle: check outputs of the previous edge, then present the next input
  task automatic applyStimulus(input bit v, input logic [7:0] d);
    @(negedge clk);
    checkOutput();
    bus.rx_valid = v;
    bus.rx_data  = d;
    model_step(v, d);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      checkOutput();
    end
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] payload, input bit good, input int max_gap);
    logic [7:0] b[6];
    b[0] = HDR;
    b[1] = payload[31:24];
    b[2] = payload[23:16];
    b[3] = payload[15:8];
    b[4] = payload[7:0];
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    if (!good) b[5] = b[5] ^ 8'h01;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, b[i]);
      if (i < 5) repeat ($urandom_range(0, max_gap)) applyStimulus(1'b0, 8'h00);
    end
  endtask

  initial begin
    int first_err;
    logic [31:0] pl;

    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    @(negedge clk);
    check("reset_uart_reg", bus.uart_reg, 32'h0);
    check("reset_err_cnt",  32'(bus.err_cnt), 32'h0);
    check("reset_ready",    32'(bus.uart_ready), 32'h0);
    rst = 1'b0;

    // junk ahead of a good frame is ignored
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h13);
    send_frame(32'hDAC00123, 1'b1, 0);
    applyStimulus(1'b0, 8'h00);
    check("good_frame_ready", 32'(bus.uart_ready), 32'd1);
    check("good_frame_reg",   bus.uart_reg, 32'hDAC00123);
    check("junk_err_cnt",     32'(bus.err_cnt), 32'd0);

    // bad checksum keeps the old register
    send_frame(32'hDAC00123, 1'b0, 0);
    applyStimulus(1'b0, 8'h00);
    check("bad_ck_err",     32'(bus.frame_err), 32'd1);
    check("bad_ck_ready",   32'(bus.uart_ready), 32'd0);
    check("bad_ck_err_cnt", 32'(bus.err_cnt), 32'd1);
    check("bad_ck_reg",     bus.uart_reg, 32'hDAC00123);

    // timeout lands TMO cycles after the last strobe
    applyStimulus(1'b1, HDR);
    applyStimulus(1'b1, 8'hDA);
    applyStimulus(1'b1, 8'hC0);
    first_err = 0;
    for (int j = 1; j <= TMO + 4; j++) begin
      applyStimulus(1'b0, 8'h00);
      if (first_err == 0 && bus.frame_err === 1'b1) first_err = j;
    end
    check("timeout_latency", 32'(first_err), 32'(TMO));
    send_frame(32'h12345678, 1'b1, 0);
    applyStimulus(1'b0, 8'h00);
    check("after_timeout_reg", bus.uart_reg, 32'h12345678);

    // a byte on the last possible cycle beats the timeout
    applyStimulus(1'b1, HDR);
    repeat (TMO - 2) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h11);
    repeat (TMO - 2) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b1, 8'h44);
    applyStimulus(1'b1, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    applyStimulus(1'b0, 8'h00);
    check("edge_timeout_reg", bus.uart_reg, 32'h11223344);

    // reset mid-frame discards the partial frame
    applyStimulus(1'b1, HDR);
    applyStimulus(1'b1, 8'hDA);
    doReset();
    ready_seen = 0;
    send_frame(32'hDAC10080, 1'b1, 0);
    repeat (3) applyStimulus(1'b0, 8'h00);
    check("reset_resume_reg",   bus.uart_reg, 32'hDAC10080);
    check("reset_resume_count", 32'(ready_seen), 32'd1);

    // back-to-back and randomised traffic, HEADER bytes inside payloads
    for (int f = 0; f < 200; f++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      pl = $urandom;
      if ($urandom_range(0, 7) == 0) pl[15:8] = HDR;
      send_frame(pl, $urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? TMO + 2 : 0);
      repeat ($urandom_range(0, 1)) applyStimulus(1'b0, 8'h00);
    end

    // error counter saturation
    doReset();
    for (int f = 1; f <= 257; f++) begin
      send_frame($urandom, 1'b0, 0);
      if (f == 256 || f == 257) begin
        applyStimulus(1'b0, 8'h00);
        check("err_cnt_saturate", 32'(bus.err_cnt), 32'hFF);
      end
    end
    repeat (3) applyStimulus(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_assembler.md
UART_REG_ASSEMBLER -- requirements
Module: uart_reg_assembler

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter HEADER, default 8'hA5, SHALL be the frame start byte.
REQ-003 Parameter TIMEOUT, default 32'd100000, SHALL be the inter-byte timeout in clk cycles.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rx_data  input  8  received UART byte, valid when rx_valid=1.
REQ-007 rx_valid  input  1  byte strobe; each high cycle SHALL count as one byte.
REQ-008 uart_reg  output  32  last good frame payload, MSB byte first; upper 16 bits carry the DAC address, lower 16 bits the code.
REQ-009 uart_ready  output  1  one-cycle pulse, asserted when uart_reg has just been updated.
REQ-010 frame_err  output  1  one-cycle pulse on checksum failure or timeout.
REQ-011 err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-012 Frame format SHALL be HEADER, then payload bytes B3 B2 B1 B0, then checksum CK = B3^B2^B1^B0.
REQ-013 The state machine SHALL have the states S_HUNT, S_DATA, S_CHECK.
REQ-014 S_HUNT: rx_valid with rx_data==HEADER -> S_DATA; byte count, XOR accumulator and timeout counter cleared; any other byte ignored, no error.
REQ-015 S_DATA: each rx_valid shifts the byte into a 32-bit shift register (left shift, new byte in [7:0]), XORs it into the accumulator and increments the byte count; after the 4th byte -> S_CHECK.
REQ-016 In S_DATA a byte equal to HEADER SHALL be treated as payload, not as a resync.
REQ-017 S_CHECK: rx_valid with rx_data==accumulator -> uart_reg <= shift register, uart_ready=1 next cycle, -> S_HUNT.
REQ-018 S_CHECK: rx_valid with rx_data!=accumulator -> frame_err=1 next cycle, uart_reg unchanged, -> S_HUNT.
REQ-019 Latency: uart_ready SHALL rise exactly 1 cycle after the checksum byte's rx_valid cycle, with uart_reg already holding the new value.
REQ-020 uart_reg SHALL hold its value between good frames; uart_ready and frame_err SHALL never assert in the same cycle.
REQ-021 Timeout counter SHALL run in S_DATA/S_CHECK, clear on each accepted byte, and hold at zero in S_HUNT.
REQ-022 When the counter reaches TIMEOUT-1 with no rx_valid in that cycle, the block SHALL pulse frame_err next cycle and go to S_HUNT.
REQ-023 If rx_valid and timeout expiry coincide, the byte SHALL win and no timeout SHALL be flagged.
REQ-024 err_cnt SHALL increment on each frame_err pulse and saturate at 8'hFF.
REQ-025 Back-to-back frames with no idle cycles SHALL all be accepted; a HEADER arriving in the cycle uart_ready is high SHALL start a new frame.

Reset
REQ-026 While rst=1: state S_HUNT, uart_reg=32'h0, uart_ready=0, frame_err=0, err_cnt=0, shift register, accumulator, byte count and timeout counter all zero.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, the first valid input is a new HEADER.

Verification
REQ-028 Bytes A5 DA C0 01 23 38 -> one uart_ready pulse one cycle after byte 38, uart_reg=32'hDAC00123, frame_err=0.
REQ-029 Bytes A5 DA C0 01 23 39 -> frame_err pulse, err_cnt=1, uart_reg unchanged, no uart_ready.
REQ-030 Bytes 00 FF 13 followed by the REQ-028 frame -> the junk is ignored, err_cnt=0, uart_reg=32'hDAC00123.
REQ-031 TIMEOUT=16; A5 DA C0 then silence -> frame_err exactly 16 cycles after the C0 strobe; the following good frame is accepted.
REQ-032 rst pulsed after A5 DA, then a full DAC1 frame A5 DA C1 00 80 9B -> uart_reg=32'hDAC10080, single uart_ready.
REQ-033 256 bad-checksum frames -> err_cnt=8'hFF, which stays at 8'hFF on the 257th error.
